// File: rtl/tran_xres_if.sv
// XRES conditioner bus: pad-side inputs and conditioned reset/warning outputs.
// master drives the inputs and observes the outputs; slave is the conditioner.
`timescale 1ns/1ps
interface tran_xres_if;
    logic       pad;
    logic       filt_in_h;
    logic       inp_sel_h;
    logic       enable_h;
    logic       en_vddio_sig_h;
    logic       enable_vddio;
    logic       disable_pullup_h;
    logic       xres_h_n;
    logic       xres_valid;
    logic       pullup_en;
    logic       warn_pad;
    logic       warn_filt;
    logic [7:0] warn_count;
    logic       warn_suppressed;

    modport master (
        output pad, filt_in_h, inp_sel_h, enable_h, en_vddio_sig_h, enable_vddio, disable_pullup_h,
        input  xres_h_n, xres_valid, pullup_en, warn_pad, warn_filt, warn_count, warn_suppressed
    );

    modport slave (
        input  pad, filt_in_h, inp_sel_h, enable_h, en_vddio_sig_h, enable_vddio, disable_pullup_h,
        output xres_h_n, xres_valid, pullup_en, warn_pad, warn_filt, warn_count, warn_suppressed
    );
endinterface

// File: rtl/tran_xres.sv
// tran_xres: conditions the external reset pad path into an active-low reset
// plus a validity flag. Selects PAD or FILT_IN_H, forces reset when the pad
// path is unpowered or the enables were sequenced badly, and flags pulses
// whose width lands in the ambiguous filter window.
// Optional build macro TRAN_XRES_DEGLITCH_EN adds a stability filter on the
// selected source before it reaches xres_h_n.
`timescale 1ns/1ps
module tran_xres #(
    parameter int MIN_WIDTH   = 5,
    parameter int MAX_WIDTH   = 60,
    parameter int MAX_WARN    = 100,
    parameter int HOLD_CYC    = 5,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    tran_xres_if.slave bus
);

    localparam int         HW       = $clog2(HOLD_CYC + 1);
    localparam logic [7:0] WARN_SAT = 8'(MAX_WARN + 1);

    typedef struct packed {
        logic pad;
        logic filt;
        logic sel;
        logic en_h;
        logic sig;
        logic vddio;
        logic dis;
    } smp_t;

    smp_t smp_raw;
    smp_t in_q;
    smp_t in_qq;

    assign smp_raw = '{pad:   bus.pad,          filt:  bus.filt_in_h,
                       sel:   bus.inp_sel_h,    en_h:  bus.enable_h,
                       sig:   bus.en_vddio_sig_h, vddio: bus.enable_vddio,
                       dis:   bus.disable_pullup_h};

    // Sample every input once; keep the previous sample for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_q  <= '0;
            in_qq <= '0;
        end else begin
            in_q  <= smp_raw;
            in_qq <= in_q;
        end
    end

    // Edge and qualification terms, all from sampled values.
    logic mode_vcchib;
    logic pad_bad;
    logic src;
    logic any_change;
    logic vddio_rise;
    logic vddio_fall;
    logic en_h_rise;
    logic en_h_fall;

    assign mode_vcchib = in_q.en_h & ~in_q.sig;
    assign pad_bad     = mode_vcchib & ~in_q.vddio;
    assign src         = in_q.sel ? in_q.filt : in_q.pad;
    assign any_change  = (in_q != in_qq);
    assign vddio_rise  = in_q.vddio & ~in_qq.vddio;
    assign vddio_fall  = ~in_q.vddio & in_qq.vddio;
    assign en_h_rise   = in_q.en_h & ~in_qq.en_h;
    assign en_h_fall   = ~in_q.en_h & in_qq.en_h;

    // Hold windows: nonzero for HOLD_CYC cycles after the reference edge.
    // The edge cycle itself is covered by the direct rise/fall term below.
    logic [HW-1:0] vrise_win_q, vrise_win_d;
    logic [HW-1:0] hfall_win_q, hfall_win_d;
    logic          viol;
    logic          corrupt_q, corrupt_d;
    logic          valid_d;

    always_comb begin
        vrise_win_d = (vrise_win_q != '0) ? vrise_win_q - 1'b1 : '0;
        hfall_win_d = (hfall_win_q != '0) ? hfall_win_q - 1'b1 : '0;
        if (vddio_rise) vrise_win_d = HW'(HOLD_CYC);
        if (en_h_fall)  hfall_win_d = HW'(HOLD_CYC);

        viol = (en_h_rise  & (vddio_rise | (vrise_win_q != '0))) |
               (vddio_fall & (en_h_fall  | (hfall_win_q != '0)));

        // A violation outranks a simultaneous input change.
        corrupt_d = corrupt_q;
        if (viol)            corrupt_d = 1'b1;
        else if (any_change) corrupt_d = 1'b0;

        valid_d = ~corrupt_d & ~(~in_q.sel & pad_bad);
    end

    // Ordering-check state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vrise_win_q <= '0;
            hfall_win_q <= '0;
            corrupt_q   <= 1'b0;
        end else begin
            vrise_win_q <= vrise_win_d;
            hfall_win_q <= hfall_win_d;
            corrupt_q   <= corrupt_d;
        end
    end

    // Source that drives xres_h_n, optionally deglitched.
    logic src_out;

`ifdef TRAN_XRES_DEGLITCH_EN
    localparam int RW = $clog2(FILT_CYCLES + 1);

    logic          src_prev;
    logic [RW-1:0] run_q, run_d;
    logic          dg_q, dg_d;

    assign src_prev = in_qq.sel ? in_qq.filt : in_qq.pad;

    always_comb begin
        run_d = RW'(1);
        if (src == src_prev)
            run_d = (run_q == RW'(FILT_CYCLES)) ? run_q : run_q + 1'b1;
        dg_d = (run_d == RW'(FILT_CYCLES)) ? src : dg_q;
    end

    // Run length of the selected source and the last stable value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q <= '0;
            dg_q  <= 1'b0;
        end else begin
            run_q <= run_d;
            dg_q  <= dg_d;
        end
    end

    assign src_out = dg_d;
`else
    assign src_out = src;
`endif

    // Per-input pulse width counters (0 = PAD, 1 = FILT_IN_H). Only the
    // selected input is allowed to raise a warning.
    logic [1:0] edge_w;
    logic [1:0] watch;
    logic [1:0] hit;
    logic       first_q;

    assign edge_w = {in_q.filt ^ in_qq.filt, in_q.pad ^ in_qq.pad};
    assign watch  = {in_q.sel, ~in_q.sel};

    for (genvar gi = 0; gi < 2; gi++) begin : g_width
        logic [CNT_W-1:0] cnt_q;

        // Cycles since the last transition; restarts at 1, saturates at all-ones.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
                cnt_q <= '0;
            else if (edge_w[gi])
                cnt_q <= CNT_W'(1);
            else if (cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end

        assign hit[gi] = edge_w[gi] & watch[gi] & ~first_q &
                         (cnt_q > CNT_W'(MIN_WIDTH)) & (cnt_q < CNT_W'(MAX_WIDTH));
    end

    // Warning tally; saturates one past MAX_WARN and latches suppression there.
    logic [7:0] warn_cnt_q, warn_cnt_d;
    logic       supp_q, supp_d;

    always_comb begin
        warn_cnt_d = warn_cnt_q;
        if ((|hit) && (warn_cnt_q != WARN_SAT))
            warn_cnt_d = warn_cnt_q + 1'b1;
        supp_d = supp_q | (warn_cnt_d == WARN_SAT);
    end

    logic xres_q;
    logic valid_q;
    logic pullup_q;
    logic wpad_q;
    logic wfilt_q;

    // Registered outputs; first_q blanks warnings on the first cycle out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            first_q    <= 1'b1;
            xres_q     <= 1'b0;
            valid_q    <= 1'b0;
            pullup_q   <= 1'b0;
            wpad_q     <= 1'b0;
            wfilt_q    <= 1'b0;
            warn_cnt_q <= '0;
            supp_q     <= 1'b0;
        end else begin
            first_q    <= 1'b0;
            xres_q     <= valid_d & src_out;
            valid_q    <= valid_d;
            pullup_q   <= ~in_q.dis;
            wpad_q     <= hit[0];
            wfilt_q    <= hit[1];
            warn_cnt_q <= warn_cnt_d;
            supp_q     <= supp_d;
        end
    end

    assign bus.xres_h_n        = xres_q;
    assign bus.xres_valid      = valid_q;
    assign bus.pullup_en       = pullup_q;
    assign bus.warn_pad        = wpad_q;
    assign bus.warn_filt       = wfilt_q;
    assign bus.warn_count      = warn_cnt_q;
    assign bus.warn_suppressed = supp_q;

endmodule

// File: tb/tb_tran_xres.sv
// Bench for tran_xres: directed table, pulse-width/warning sequences,
// optional deglitch sequence, and randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_tran_xres;

    localparam int MIN_W    = 5;
    localparam int MAX_W    = 60;
    localparam int MAX_WARN = 100;
    localparam int HOLD     = 5;
    localparam int FILT     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tran_xres_if bus();

    tran_xres #(
        .MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W), .MAX_WARN(MAX_WARN),
        .HOLD_CYC(HOLD), .FILT_CYCLES(FILT), .CNT_W(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic pad;
        logic filt;
        logic sel;
        logic en_h;
        logic sig;
        logic vddio;
        logic dis;
    } in_t;

    typedef struct {
        in_t        in;
        int         hold;
        logic [2:0] e;      // {xres_h_n, xres_valid, pullup_en}
    } vec_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    in_t  cur;
    int   wp_seen, wf_seen;

    // Reference model state: event timestamps rather than counters.
    int   m_e;
    in_t  m_s1, m_s2;
    int   m_t_pad, m_t_filt, m_t_vr, m_t_hf;
    bit   m_corrupt;
    int   m_wcount;
    bit   m_hist [FILT];
    bit   m_filt_v;
    bit   ex_x, ex_v, ex_p, ex_wp, ex_wf, ex_sup;
    int   ex_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.pad              = cur.pad;
        bus.filt_in_h        = cur.filt;
        bus.inp_sel_h        = cur.sel;
        bus.enable_h         = cur.en_h;
        bus.en_vddio_sig_h   = cur.sig;
        bus.enable_vddio     = cur.vddio;
        bus.disable_pullup_h = cur.dis;
    endtask

    task automatic model_reset();
        m_e = 0; m_s1 = '0; m_s2 = '0;
        m_t_pad = 0; m_t_filt = 0; m_t_vr = -1000; m_t_hf = -1000;
        m_corrupt = 1'b0; m_wcount = 0; m_filt_v = 1'b0;
        for (int i = 0; i < FILT; i++) m_hist[i] = 1'b0;
        ex_x = 0; ex_v = 0; ex_p = 0; ex_wp = 0; ex_wf = 0; ex_sup = 0; ex_cnt = 0;
    endtask

    // One clock edge of the model: outputs follow the sample taken one edge earlier.
    task automatic model_update(input in_t now);
        int k, wp, wf;
        bit ptr, ftr, vr, vf, hr, hf, viol, src, same;
        m_e++;
        k   = m_e - 1;
        ptr = m_s1.pad  != m_s2.pad;
        ftr = m_s1.filt != m_s2.filt;
        wp  = k - m_t_pad;
        wf  = k - m_t_filt;
        if (wp > 65535) wp = 65535;
        if (wf > 65535) wf = 65535;
        if (ptr) m_t_pad  = k;
        if (ftr) m_t_filt = k;
        vr = m_s1.vddio && !m_s2.vddio;
        vf = !m_s1.vddio && m_s2.vddio;
        hr = m_s1.en_h && !m_s2.en_h;
        hf = !m_s1.en_h && m_s2.en_h;
        if (vr) m_t_vr = k;
        if (hf) m_t_hf = k;
        viol = (hr && (k - m_t_vr) <= HOLD) || (vf && (k - m_t_hf) <= HOLD);
        if (viol) m_corrupt = 1'b1;
        else if (m_s1 != m_s2) m_corrupt = 1'b0;
        ex_v = !m_corrupt && !(!m_s1.sel && m_s1.en_h && !m_s1.sig && !m_s1.vddio);
        src  = m_s1.sel ? m_s1.filt : m_s1.pad;
`ifdef TRAN_XRES_DEGLITCH_EN
        for (int i = FILT - 1; i > 0; i--) m_hist[i] = m_hist[i - 1];
        m_hist[0] = src;
        same = 1'b1;
        for (int i = 1; i < FILT; i++) if (m_hist[i] != src) same = 1'b0;
        if (same) m_filt_v = src;
        ex_x = ex_v && m_filt_v;
`else
        same = 1'b0;
        ex_x = ex_v && src;
`endif
        ex_p  = !m_s1.dis;
        ex_wp = ptr && !m_s1.sel && wp > MIN_W && wp < MAX_W && m_e > 1;
        ex_wf = ftr &&  m_s1.sel && wf > MIN_W && wf < MAX_W && m_e > 1;
        if ((ex_wp || ex_wf) && m_wcount < MAX_WARN + 1) m_wcount++;
        ex_cnt = m_wcount;
        ex_sup = m_wcount > MAX_WARN;
        m_s2 = m_s1;
        m_s1 = now;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_update(cur);
        @(negedge clk);
        if (bus.warn_pad)  wp_seen++;
        if (bus.warn_filt) wf_seen++;
        if (chk_en) begin
            chk("m_xres",   int'(bus.xres_h_n),        int'(ex_x));
            chk("m_valid",  int'(bus.xres_valid),      int'(ex_v));
            chk("m_pullup", int'(bus.pullup_en),       int'(ex_p));
            chk("m_wpad",   int'(bus.warn_pad),        int'(ex_wp));
            chk("m_wfilt",  int'(bus.warn_filt),       int'(ex_wf));
            chk("m_wcount", int'(bus.warn_count),      ex_cnt);
            chk("m_supp",   int'(bus.warn_suppressed), int'(ex_sup));
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_xres"},   int'(bus.xres_h_n),        0);
        chk({tag, "_valid"},  int'(bus.xres_valid),      0);
        chk({tag, "_pullup"}, int'(bus.pullup_en),       0);
        chk({tag, "_wpad"},   int'(bus.warn_pad),        0);
        chk({tag, "_wfilt"},  int'(bus.warn_filt),       0);
        chk({tag, "_wcount"}, int'(bus.warn_count),      0);
        chk({tag, "_supp"},   int'(bus.warn_suppressed), 0);
    endtask

    // Asynchronous reset mid-operation, released on a falling edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        model_reset();
        hold(2);
        rst = 1'b0;
        $display("async reset applied and released at t=%0t", $time);
    endtask

    task automatic pad_pulse(input int hi, input int lo);
        cur.pad = 1'b1; drive(); hold(hi);
        cur.pad = 1'b0; drive(); hold(lo);
    endtask

    task automatic filt_pulse(input int hi, input int lo);
        cur.filt = 1'b1; drive(); hold(hi);
        cur.filt = 1'b0; drive(); hold(lo);
    endtask

    function automatic vec_t mk(input logic [6:0] i, input int h, input logic [2:0] e);
        vec_t v;
        v.in   = in_t'(i);
        v.hold = h;
        v.e    = e;
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        // bits: pad filt sel en_h sig vddio dis ; expected {xres, valid, pullup}
        tbl[0]  = mk(7'b0000110, 8, 3'b011);   // VDDIO up well before ENABLE_H
        tbl[1]  = mk(7'b1001110, 1, 3'b011);   // one edge: not yet visible
        tbl[2]  = mk(7'b1001110, 1, 3'b111);   // two edges: PAD reaches output
        tbl[3]  = mk(7'b1001000, 3, 3'b001);   // vcchib mode with VDDIO off
        tbl[4]  = mk(7'b1111000, 3, 3'b111);   // switch to FILT_IN_H
        tbl[5]  = mk(7'b1110000, 8, 3'b111);   // ENABLE_H falls
        tbl[6]  = mk(7'b1110010, 2, 3'b111);   // ENABLE_VDDIO rises
        tbl[7]  = mk(7'b1111010, 2, 3'b001);   // ENABLE_H rises 2 later: corrupt
        tbl[8]  = mk(7'b1111011, 2, 3'b110);   // any change clears corrupt
        tbl[9]  = mk(7'b1110011, 1, 3'b110);   // ENABLE_H falls
        tbl[10] = mk(7'b1110001, 2, 3'b000);   // VDDIO falls 1 later: corrupt
        tbl[11] = mk(7'b1110000, 2, 3'b111);   // pull-up toggle clears corrupt
        tbl[12] = mk(7'b0000110, 2, 3'b011);   // back to PAD source

        wp_seen = 0; wf_seen = 0;
        cur = '0; drive();
        model_reset();
        rst = 1'b1;
        hold(3);
        chk_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        for (int r = 0; r < 13; r++) begin
            cur = tbl[r].in; drive();
            hold(tbl[r].hold);
            chk("row_xres",   int'(bus.xres_h_n),   int'(tbl[r].e[2]));
            chk("row_valid",  int'(bus.xres_valid), int'(tbl[r].e[1]));
            chk("row_pullup", int'(bus.pullup_en),  int'(tbl[r].e[0]));
            $display("row %0d in=%b -> xres=%b valid=%b pullup=%b", r, tbl[r].in,
                     bus.xres_h_n, bus.xres_valid, bus.pullup_en);
        end

        // Pulse widths 3, 20, 100 on PAD: only the 20-cycle pulse is ambiguous.
        do_reset();
        cur = in_t'(7'b0000110); drive();
        hold(70);
        wp_seen = 0; wf_seen = 0;
        pad_pulse(3, 70);
        pad_pulse(20, 70);
        pad_pulse(100, 70);
        chk("pad_warn_pulses", wp_seen, 1);
        chk("pad_warn_count", int'(bus.warn_count), 1);
        $display("pad pulses 3/20/100: warn_pad pulses=%0d warn_count=%0d", wp_seen, bus.warn_count);

        // FILT_IN_H pulses warn only while selected.
        filt_pulse(20, 70);
        chk("filt_unsel_pulses", wf_seen, 0);
        cur.sel = 1'b1; drive(); hold(70);
        filt_pulse(20, 70);
        chk("filt_sel_pulses", wf_seen, 1);
        chk("filt_warn_count", int'(bus.warn_count), 2);
        $display("filt pulses: warn_filt pulses=%0d warn_count=%0d", wf_seen, bus.warn_count);

        // Saturation of the warning count.
        do_reset();
        cur = in_t'(7'b0000110); drive();
        hold(70);
        for (int i = 0; i < 100; i++) pad_pulse(20, 70);
        chk("sat_cnt_100", int'(bus.warn_count), 100);
        chk("sat_supp_100", int'(bus.warn_suppressed), 0);
        pad_pulse(20, 70);
        pad_pulse(20, 70);
        chk("sat_cnt_102", int'(bus.warn_count), 101);
        chk("sat_supp_102", int'(bus.warn_suppressed), 1);
        pad_pulse(20, 70);
        chk("sat_cnt_103", int'(bus.warn_count), 101);
        $display("saturation: warn_count=%0d suppressed=%b", bus.warn_count, bus.warn_suppressed);

`ifdef TRAN_XRES_DEGLITCH_EN
        do_reset();
        cur = in_t'(7'b0000110); drive();
        hold(20);
        chk("dg_idle", int'(bus.xres_h_n), 0);
        cur.pad = 1'b1; drive(); hold(2);
        cur.pad = 1'b0; drive();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("dg_glitch", int'(bus.xres_h_n), 0);
        end
        cur.pad = 1'b1; drive(); hold(10);
        chk("dg_pulse", int'(bus.xres_h_n), 1);
        $display("deglitch: 2-cycle glitch blocked, 10-cycle pulse xres=%b", bus.xres_h_n);
`endif

        // Randomized traffic against the model, with one reset in the middle.
        do_reset();
        cur = in_t'(7'b0000110); drive();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            cur.pad   ^= ($urandom_range(0, 14) == 0);
            cur.filt  ^= ($urandom_range(0, 14) == 0);
            cur.sel   ^= ($urandom_range(0, 59) == 0);
            cur.en_h  ^= ($urandom_range(0, 24) == 0);
            cur.sig   ^= ($urandom_range(0, 39) == 0);
            cur.vddio ^= ($urandom_range(0, 24) == 0);
            cur.dis   ^= ($urandom_range(0, 49) == 0);
            drive();
            step();
        end
        $display("random: 4000 cycles, warn_count=%0d", bus.warn_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
